// File: rtl/rsa_half_power_mod.sv
// rsa_half_power_mod
//   Computes o_out = i_value * 2^(-i_power) mod i_modulus by modular halving,
//   one halving per clock. Used on the Montgomery output path to leave the
//   Montgomery domain (x * R^-1 mod N, R = 2^k). The modulus must be odd.
//
//   Optional build macro: RSA_HALF_POWER_MOD_CHECK_EN
//     adds o_error (latched at acceptance for even/zero N or x >= N); an
//     errored request skips CALC and returns o_out = 0.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous active-low reset
//   i_valid    request valid
//   i_ready    block idle and able to accept a request
//   i_modulus  odd modulus N
//   i_value    operand x, 0 <= x < N
//   i_power    halving count k
//   o_valid    result valid (held until o_ready)
//   o_ready    downstream accepts result
//   o_out      x * 2^-k mod N
//   o_error    (macro only) request was out of contract
module rsa_half_power_mod #(
  parameter int MOD_WIDTH   = 256,
  parameter int POWER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [MOD_WIDTH-1:0]   i_modulus,
  input  logic [MOD_WIDTH-1:0]   i_value,
  input  logic [POWER_WIDTH-1:0] i_power,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [MOD_WIDTH-1:0]   o_out
`ifdef RSA_HALF_POWER_MOD_CHECK_EN
  ,
  output logic                   o_error
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [MOD_WIDTH:0]     acc_q;
  logic [MOD_WIDTH-1:0]   n_q;
  logic [POWER_WIDTH-1:0] k_q;
  logic [POWER_WIDTH-1:0] cnt_q;

  logic [MOD_WIDTH:0]     half_sum;
  logic [MOD_WIDTH:0]     acc_next;
  logic [POWER_WIDTH-1:0] k_last;
  logic                   last_step;
  logic                   accept;
  logic                   chk_err;

  assign i_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_out   = acc_q[MOD_WIDTH-1:0];
  assign accept  = i_valid && (state_q == IDLE);

  // acc < N keeps acc + N below 2^(MOD_WIDTH+1); an odd acc plus odd N is
  // even, so the shift is an exact division and the result stays below N.
  assign half_sum = acc_q + {1'b0, n_q};
  assign acc_next = acc_q[0] ? (half_sum >> 1) : (acc_q >> 1);

  // Terminal compare at POWER_WIDTH bits: k = all-ones ends at cnt = k-1
  // without the counter ever wrapping.
  assign k_last    = k_q - POWER_WIDTH'(1);
  assign last_step = (cnt_q == k_last);

`ifdef RSA_HALF_POWER_MOD_CHECK_EN
  logic err_q;
  assign chk_err = !i_modulus[0] || (i_value >= i_modulus) || (i_modulus == '0);
  assign o_error = err_q;

  always_ff @(posedge clk) begin
    if (!rst)                                err_q <= 1'b0;
    else if (state_q == IDLE && i_valid)     err_q <= chk_err;
  end
`else
  assign chk_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (chk_err || i_power == '0) ? DONE : CALC;
      end
      CALC: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        if (o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      n_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            n_q   <= i_modulus;
            k_q   <= i_power;
            cnt_q <= '0;
            acc_q <= chk_err ? '0 : {1'b0, i_value};
          end
        end
        CALC: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + POWER_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
